// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg -- shared widths, encodings and the request record for the
// memory-port arbiter.
//
// The global `defines (XLEN, op width, ROB tag width, op codes, arb_kind and
// FSM state codes) live at the top of this file so every unit compiled after it
// sees one consistent set. The package re-exports them as typed localparams.
//
// Optional feature macro consumed by mem_arbiter: MEM_ARB_AGING_EN.

`ifndef MEM_ARBITER_GLOBALS
`define MEM_ARBITER_GLOBALS
`define XLEN            32
`define INST_OP_WIDTH   6
`define ROB_SIZE_WIDTH  4
// op codes (fetches always carry OP_NONE)
`define OP_NONE         6'd0
`define OP_LB           6'd1
`define OP_LW           6'd3
`define OP_SB           6'd9
`define OP_SW           6'd11
// arb_kind encodings
`define ARB_KIND_NONE   2'd0
`define ARB_KIND_FETCH  2'd1
`define ARB_KIND_LOAD   2'd2
`define ARB_KIND_STORE  2'd3
// FSM state encodings
`define ARB_ST_IDLE     2'd0
`define ARB_ST_ISSUE    2'd1
`define ARB_ST_WAIT     2'd2
`endif

package mem_arbiter_pkg;

  localparam int XLEN = `XLEN;
  localparam int OPW  = `INST_OP_WIDTH;
  localparam int IDW  = `ROB_SIZE_WIDTH;

  localparam logic [1:0] KIND_NONE  = `ARB_KIND_NONE;
  localparam logic [1:0] KIND_FETCH = `ARB_KIND_FETCH;
  localparam logic [1:0] KIND_LOAD  = `ARB_KIND_LOAD;
  localparam logic [1:0] KIND_STORE = `ARB_KIND_STORE;

  localparam logic [1:0] S_IDLE  = `ARB_ST_IDLE;
  localparam logic [1:0] S_ISSUE = `ARB_ST_ISSUE;
  localparam logic [1:0] S_WAIT  = `ARB_ST_WAIT;

  // One granted access as presented to the memory controller.
  typedef struct packed {
    logic [1:0]      kind;
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] val;
    logic [IDW-1:0]  id;
  } arb_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter -- single-port memory arbiter between instruction fetch, LSB
// loads and ROB committed stores.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   flush, stall        branch flush, global issue stall
//   icache_*            fetch request (level) + address
//   lsb_*               load request + op/addr/ROB tag
//   rob_*               committed store request + op/addr/data
//   mem_done            completion pulse from the memory controller
//   *_gnt               one-cycle grant pulse to the selected requester
//   arb_valid           issue strobe (ISSUE state only)
//   arb_kind/op/addr/val/id  registered granted request, stable until done
//   arb_busy            high in ISSUE and WAIT
//
// FSM: IDLE -> ISSUE (1 cycle) -> WAIT -> IDLE on mem_done.
// Priority: store > load > fetch.
// Build option MEM_ARB_AGING_EN: a saturating fetch age counter lets a fetch
// that has waited AGE_LIMIT cycles beat a load (never a store). Without it
// AGE_LIMIT is accepted but has no effect.

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AGE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       stall,
  input  logic                       icache_req,
  input  logic [`XLEN-1:0]           icache_addr,
  input  logic                       lsb_req,
  input  logic [`INST_OP_WIDTH-1:0]  lsb_op,
  input  logic [`XLEN-1:0]           lsb_addr,
  input  logic [`ROB_SIZE_WIDTH-1:0] lsb_id,
  input  logic                       rob_req,
  input  logic [`INST_OP_WIDTH-1:0]  rob_op,
  input  logic [`XLEN-1:0]           rob_addr,
  input  logic [`XLEN-1:0]           rob_val,
  input  logic                       mem_done,
  output logic                       icache_gnt,
  output logic                       lsb_gnt,
  output logic                       rob_gnt,
  output logic                       arb_valid,
  output logic [1:0]                 arb_kind,
  output logic [`INST_OP_WIDTH-1:0]  arb_op,
  output logic [`XLEN-1:0]           arb_addr,
  output logic [`XLEN-1:0]           arb_val,
  output logic [`ROB_SIZE_WIDTH-1:0] arb_id,
  output logic                       arb_busy
);

  logic [1:0] r_state;
  arb_req_t   r_cur;
  arb_req_t   w_sel;
  logic       w_age_hit;
  logic       w_drop;

`ifdef MEM_ARB_AGING_EN
  localparam int AGE_W = (AGE_LIMIT < 1) ? 1 : $clog2(AGE_LIMIT + 1);
  logic [AGE_W-1:0] r_age;

  assign w_age_hit = (r_age == AGE_W'(AGE_LIMIT));

  // Counts cycles a fetch has been left waiting; saturates at AGE_LIMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_age <= '0;
    else if (icache_gnt || flush) r_age <= '0;
    else if (icache_req && !w_age_hit) r_age <= r_age + AGE_W'(1);
  end
`else
  assign w_age_hit = 1'b0;
`endif

  // Priority select. Grants only from IDLE and never during reset; a flush in
  // IDLE still lets a committed store through, since it is not speculative.
  always_comb begin
    w_sel = '0;
    if (!rst && r_state == S_IDLE && !stall) begin
      if (rob_req) begin
        w_sel.kind = KIND_STORE;
        w_sel.op   = rob_op;
        w_sel.addr = rob_addr;
        w_sel.val  = rob_val;
      end else if (!flush) begin
        if (icache_req && (w_age_hit || !lsb_req)) begin
          w_sel.kind = KIND_FETCH;
          w_sel.addr = icache_addr;
        end else if (lsb_req) begin
          w_sel.kind = KIND_LOAD;
          w_sel.op   = lsb_op;
          w_sel.addr = lsb_addr;
          w_sel.id   = lsb_id;
        end
      end
    end
  end

  assign icache_gnt = (w_sel.kind == KIND_FETCH);
  assign lsb_gnt    = (w_sel.kind == KIND_LOAD);
  assign rob_gnt    = (w_sel.kind == KIND_STORE);

  // Speculative accesses are abandoned on flush; stores run to completion.
  assign w_drop = flush && (r_cur.kind != KIND_STORE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_sel.kind != KIND_NONE) begin
            r_cur   <= w_sel;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // mem_done cannot belong to this access yet, so it is ignored here.
          if (w_drop) begin
            r_state    <= S_IDLE;
            r_cur.kind <= KIND_NONE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_done || w_drop) begin
            r_state    <= S_IDLE;
            r_cur.kind <= KIND_NONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cur   <= '0;
        end
      endcase
    end
  end

  assign arb_valid = (r_state == S_ISSUE);
  assign arb_busy  = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign arb_kind  = r_cur.kind;
  assign arb_op    = r_cur.op;
  assign arb_addr  = r_cur.addr;
  assign arb_val   = r_cur.val;
  assign arb_id    = r_cur.id;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AGE_LIMIT, default 8, fetch-wait cycles before a fetch is forced to win arbitration.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 flush  input  1  branch-mispredict flush, sampled at posedge.
REQ-005 stall  input  1  global stall; no new issue while high.
REQ-006 icache_req / icache_addr  input  1 / `XLEN  fetch request (level) and fetch address.
REQ-007 lsb_req / lsb_op / lsb_addr / lsb_id  input  1 / `INST_OP_WIDTH / `XLEN / `ROB_SIZE_WIDTH  load request.
REQ-008 rob_req / rob_op / rob_addr / rob_val  input  1 / `INST_OP_WIDTH / `XLEN / `XLEN  committed store request.
REQ-009 mem_done  input  1  one-cycle pulse from the byte-sequencing memory controller when the issued access finishes.
REQ-010 icache_gnt / lsb_gnt / rob_gnt  output  1 each  one-cycle grant pulse; the requester drops or changes its request on the next cycle.
REQ-011 arb_valid  output  1  one-cycle issue strobe to the memory controller.
REQ-012 arb_kind  output  2  0 = none, 1 = fetch, 2 = load, 3 = store.
REQ-013 arb_op / arb_addr / arb_val / arb_id  output  `INST_OP_WIDTH / `XLEN / `XLEN / `ROB_SIZE_WIDTH  registered copy of the granted request.
REQ-014 arb_busy  output  1  high from issue until mem_done, inclusive of the issue cycle.

Function
REQ-015 The arbiter SHALL use a three-state FSM: IDLE -> ISSUE (one cycle) -> WAIT -> IDLE when mem_done is seen.
REQ-016 In IDLE, with stall low and at least one request high, the arbiter SHALL select a requester, register its fields, pulse its gnt, and enter ISSUE on the next posedge.
REQ-017 Fixed priority SHALL be store > load > fetch, except as modified by REQ-025.
REQ-018 arb_valid SHALL be high exactly during ISSUE, and arb_kind/op/addr/val/id SHALL hold stable from ISSUE until the WAIT -> IDLE transition.
REQ-019 A fetch grant SHALL drive arb_op = 0, arb_val = 0 and arb_id = 0; a store grant SHALL drive arb_id = 0.
REQ-020 The minimum spacing between consecutive arb_valid pulses SHALL be 3 cycles (ISSUE, WAIT seeing mem_done, IDLE issue); back-to-back grant pulses SHALL therefore be at least 3 cycles apart.
REQ-021 A mem_done seen in IDLE or ISSUE SHALL be ignored.
REQ-022 On flush with a fetch or load in ISSUE/WAIT, the FSM SHALL return to IDLE next cycle, deassert arb_busy, and not wait for mem_done.
REQ-023 On flush with a store in ISSUE/WAIT, the store SHALL continue unchanged until mem_done, because committed stores are never abandoned.
REQ-024 Flush in IDLE SHALL suppress any grant in that cycle; a rob_req in the same cycle SHALL still be granted.

Reset
REQ-026 While rst is high, the FSM SHALL be IDLE; all gnt, arb_valid and arb_busy SHALL be 0; arb_kind/op/addr/val/id SHALL be 0; the age counter SHALL be 0.
REQ-027 Reset asserted mid-access SHALL abandon the access immediately, including stores.
REQ-028 After reset deasserts, the first grant SHALL be possible on the first posedge.

Configuration
REQ-025 With MEM_ARB_AGING_EN defined:
- A saturating age counter SHALL increment each cycle icache_req is high and not granted.
- It SHALL clear on icache_gnt or flush.
- When it equals AGE_LIMIT, the fetch SHALL beat a load but never a store.
REQ-029 Without MEM_ARB_AGING_EN, no counter SHALL exist and pure fixed priority SHALL apply; the AGE_LIMIT parameter SHALL remain present but unused.

Structure
REQ-030 arb_kind encodings and FSM state encodings SHALL be `defines in global_params.v, alongside `XLEN and the op codes.
REQ-031 The block SHALL be a single module with no sub-module.
REQ-032 The priority select SHALL be one combinational always block.

Verification
REQ-033 Reset mid-WAIT on a store at addr 0x100 -> FSM IDLE and arb_busy 0 the same cycle; no further rob_gnt until rob_req is re-sampled.
REQ-034 All three requests high in IDLE (rob_addr 0x20, lsb_addr 0x40, icache_addr 0x0) -> rob_gnt first, then lsb_gnt, then icache_gnt, each after the prior mem_done, with arb_kind 3, 2, 1.
REQ-035 Load in WAIT plus flush -> arb_busy 0 next cycle; a later stray mem_done is ignored; a fetch is granted on the following cycle.
REQ-036 Store in WAIT plus flush -> arb_busy stays 1 until mem_done, and arb_addr holds its value throughout.
REQ-037 With the aging feature enabled and AGE_LIMIT=8, hold icache_req and lsb_req continuously -> icache_gnt no later than after the 8th waiting cycle; with the feature disabled, no icache_gnt while lsb_req stays high.
REQ-038 stall high with requests pending -> no grants; deassert stall -> a grant in the same cycle.
